// File: rtl/scroll_display.sv
// scroll_display
//   Scrolls a fixed 16-character hex message across a 4-digit common-anode
//   7-segment display. Each accepted tick moves the message one character
//   left or right; the four digits are time-multiplexed from a free-running
//   refresh counter.
//
// Ports
//   clk     in   1  system clock
//   reset   in   1  asynchronous, active-high
//   tick    in   1  scroll strobe (one step per cycle it is high)
//   run     in   1  1 = ticks advance the scroll, 0 = freeze
//   dir     in   1  0 = scroll left (offset+1), 1 = scroll right (offset-1)
//   an      out  4  digit enables, active-low, an[3] = leftmost digit
//   seg     out  7  segments a..g on seg[6]..seg[0], active-low
//   offset  out  4  message index shown on the leftmost digit
module scroll_display #(
  parameter logic [63:0] MSG          = 64'h0123456789ABCDEF,
  parameter int          REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic       dir,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [3:0] offset
);

  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              sel;
  logic [3:0]              char_idx;
  logic [3:0]              char_code;
  logic [3:0]              an_next;
  logic [6:0]              seg_next;

  // Top two refresh bits pick the digit being driven; digit 0 is leftmost.
  assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    char_idx  = offset + {2'b00, sel};
    // Character i lives at MSG[63-4*i -: 4], i.e. LSB at 4*(15-i).
    char_code = MSG[{4'd15 - char_idx, 2'b00} +: 4];
    an_next   = ~(4'b1000 >> sel);
    case (char_code)
      4'h0:    seg_next = 7'b0000001;
      4'h1:    seg_next = 7'b1001111;
      4'h2:    seg_next = 7'b0010010;
      4'h3:    seg_next = 7'b0000110;
      4'h4:    seg_next = 7'b1001100;
      4'h5:    seg_next = 7'b0100100;
      4'h6:    seg_next = 7'b0100000;
      4'h7:    seg_next = 7'b0001111;
      4'h8:    seg_next = 7'b0000000;
      4'h9:    seg_next = 7'b0000100;
      4'hA:    seg_next = 7'b0001000;
      4'hB:    seg_next = 7'b1100000;
      4'hC:    seg_next = 7'b0110001;
      4'hD:    seg_next = 7'b1000010;
      4'hE:    seg_next = 7'b0110000;
      default: seg_next = 7'b0111000;
    endcase
  end

  // an/seg are registered from the pre-edge sel/offset, so a tick landing on
  // a digit switch shows the old offset for that one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      offset      <= '0;
      an          <= '1;
      seg         <= '1;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      if (tick && run) begin
        offset <= dir ? offset - 4'd1 : offset + 4'd1;
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_scroll_display.sv
module tb_scroll_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       run;
  logic       dir;
  logic [3:0] an;
  logic [6:0] seg;
  logic [3:0] offset;

  int passed = 0;
  int total  = 0;

  scroll_display #(
    .MSG          (64'h0123456789ABCDEF),
    .REFRESH_BITS (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .run    (run),
    .dir    (dir),
    .an     (an),
    .seg    (seg),
    .offset (offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       run;
    logic       dir;
    logic [3:0] an;
    int         ch;
    logic [3:0] off;
  } vec_t;

  vec_t vecs[$];

  logic [3:0] ans [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [6:0] glyph(input int c);
    case (c)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      10:      return 7'b0001000;
      11:      return 7'b1100000;
      12:      return 7'b0110001;
      13:      return 7'b1000010;
      14:      return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic void add(input logic t, input logic r, input logic d,
                              input logic [3:0] a, input int c, input int o);
    vec_t v;
    v.tick = t; v.run = r; v.dir = d; v.an = a; v.ch = c; v.off = 4'(o);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [6:0] act,
                     input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
  endtask

  task automatic chk_all(input string name, input int idx, input logic [3:0] ea,
                         input logic [6:0] es, input logic [3:0] eo);
    chk({name, ".an"},     idx, {3'b000, an},     {3'b000, ea});
    chk({name, ".seg"},    idx, seg,              es);
    chk({name, ".offset"}, idx, {3'b000, offset}, {3'b000, eo});
  endtask

  initial begin
    // Idle sweep from reset release: one full refresh period at offset 0.
    for (int i = 0; i < 16; i++) add(0, 1, 0, ans[i/4], i/4, 0);
    // 16 consecutive ticks left; display uses the pre-edge offset.
    add(1, 1, 0, ans[0], 0, 1);   add(1, 1, 0, ans[0], 1, 2);
    add(1, 1, 0, ans[0], 2, 3);   add(1, 1, 0, ans[0], 3, 4);
    add(1, 1, 0, ans[1], 5, 5);   add(1, 1, 0, ans[1], 6, 6);
    add(1, 1, 0, ans[1], 7, 7);   add(1, 1, 0, ans[1], 8, 8);
    add(1, 1, 0, ans[2], 10, 9);  add(1, 1, 0, ans[2], 11, 10);
    add(1, 1, 0, ans[2], 12, 11); add(1, 1, 0, ans[2], 13, 12);
    add(1, 1, 0, ans[3], 15, 13); add(1, 1, 0, ans[3], 0, 14);
    add(1, 1, 0, ans[3], 1, 15);  add(1, 1, 0, ans[3], 2, 0);
    // One right tick from 0 wraps to 15; then digits show F,0,1,2.
    add(1, 1, 1, ans[0], 0, 15);
    for (int i = 1; i < 16; i++) add(0, 1, 0, ans[i/4], (15 + i/4) % 16, 15);
    // One more right tick -> 14; digits show E,F,0,1.
    add(1, 1, 1, ans[0], 15, 14);
    for (int i = 1; i < 16; i++) add(0, 1, 0, ans[i/4], (14 + i/4) % 16, 14);
    // run=0: ticks ignored, refresh keeps moving.
    add(1, 0, 0, ans[0], 14, 14); add(1, 0, 0, ans[0], 14, 14);
    add(1, 0, 1, ans[0], 14, 14); add(1, 0, 0, ans[0], 14, 14);
    add(1, 0, 1, ans[1], 15, 14);
    // Right ticks down to offset 7, ending inside the digit-3 slot.
    add(1, 1, 1, ans[1], 15, 13); add(1, 1, 1, ans[1], 14, 12);
    add(1, 1, 1, ans[1], 13, 11); add(1, 1, 1, ans[2], 13, 10);
    add(1, 1, 1, ans[2], 12, 9);  add(1, 1, 1, ans[2], 11, 8);
    add(1, 1, 1, ans[2], 10, 7);
    add(0, 1, 0, ans[3], 10, 7);

    reset = 1'b1; tick = 1'b0; run = 1'b1; dir = 1'b0;
    #1;
    chk_all("reset_t0", 0, 4'b1111, 7'b1111111, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_all("reset_hold", i, 4'b1111, 7'b1111111, 4'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      tick = vecs[i].tick; run = vecs[i].run; dir = vecs[i].dir;
      @(posedge clk); #1;
      chk_all("vec", i, vecs[i].an, glyph(vecs[i].ch), vecs[i].off);
    end

    // Asynchronous reset in the middle of the digit-3 slot at offset 7.
    tick = 1'b0; run = 1'b1; dir = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 4'b1111, 7'b1111111, 4'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_all("async_hold", i, 4'b1111, 7'b1111111, 4'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_all("restart_d0", i, 4'b0111, glyph(0), 4'd0);
    end
    @(posedge clk); #1;
    chk_all("restart_d1", 0, 4'b1011, glyph(1), 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
